// File: rtl/subtrator_serial_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor controller.
// master: requester side, slave: controller side.
interface subtrator_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock, built around
// a single shared 1-bit full subtractor cell. Outputs are all registered
// and only change on the edge that completes an operation.

// 1-bit full subtractor: S = A - B - Cin, Cout is the borrow out.
module subtratorcompleto (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S    = A ^ B ^ Cin;
  assign Cout = (~A & B) | (~(A ^ B) & Cin);
endmodule

module subtrator_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  subtrator_serial_ctrl_if.slave  bus
);
  // Counter needs at least one bit so the WIDTH=1 build still has a register.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   sa_r;
  logic [WIDTH-1:0]   sb_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_shift_s;
  logic               bflop_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               cnt_last_s;
  logic               a_msb_r;
  logic               b_msb_r;
  logic               cell_s_s;
  logic               cell_cout_s;
  logic               load_s;
  logic               last_s;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   diff_r;
  logic               borrow_out_r;
  logic               overflow_r;

  // The one shared cell always works on the current LSBs and the running borrow.
  subtratorcompleto u_cell (
    .A    (sa_r[0]),
    .B    (sb_r[0]),
    .Cin  (bflop_r),
    .S    (cell_s_s),
    .Cout (cell_cout_s)
  );

  assign cnt_last_s = (cnt_r == CNT_W'(WIDTH - 1));

  // Result register with the new difference bit entering at the MSB end.
  always_comb begin
    res_shift_s            = res_r >> 1'b1;
    res_shift_s[WIDTH-1]   = cell_s_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: DONE always falls back to IDLE, so start is only seen in IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_last_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: control strobes and next values of the registered flags.
  always_comb begin
    load_s     = 1'b0;
    last_s     = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    if (state_r == ST_IDLE) begin
      load_s = bus.start;
    end else if (state_r == ST_RUN) begin
      last_s = cnt_last_s;
    end else begin
      load_s = 1'b0;
    end
    busy_nxt_s = (state_next_s == ST_RUN);
    done_nxt_s = (state_next_s == ST_DONE);
  end

  // Operand shifters, borrow feedback and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_r    <= {WIDTH{1'b0}};
      sb_r    <= {WIDTH{1'b0}};
      res_r   <= {WIDTH{1'b0}};
      bflop_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
    end else if (load_s) begin
      sa_r    <= bus.a;
      sb_r    <= bus.b;
      bflop_r <= bus.borrow_in;
      cnt_r   <= {CNT_W{1'b0}};
      a_msb_r <= bus.a[WIDTH-1];
      b_msb_r <= bus.b[WIDTH-1];
    end else if (state_r == ST_RUN) begin
      sa_r    <= sa_r >> 1'b1;
      sb_r    <= sb_r >> 1'b1;
      res_r   <= res_shift_s;
      bflop_r <= cell_cout_s;
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Registered outputs; results load only on the completing edge so they never show partial values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      diff_r       <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (last_s) begin
        diff_r       <= res_shift_s;
        borrow_out_r <= cell_cout_s;
        overflow_r   <= (a_msb_r != b_msb_r) && (cell_s_s != a_msb_r);
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.diff       = diff_r;
  assign bus.borrow_out = borrow_out_r;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Self-checking bench for subtrator_serial_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_subtrator_serial_ctrl;
  typedef struct packed {
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  res_t q8[$];
  res_t q1[$];
  logic [7:0] exp_last_diff;

  always #5 clk = ~clk;

  subtrator_serial_ctrl_if #(.WIDTH(8)) bus8 ();
  subtrator_serial_ctrl_if #(.WIDTH(1)) bus1 ();

  subtrator_serial_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  subtrator_serial_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  function automatic res_t model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] full;
    res_t r;
    full     = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    r.diff   = full[7:0];
    r.borrow = full[8];
    r.ovf    = (a[7] != b[7]) && (r.diff[7] != a[7]);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.borrow_in = 1'b0;
    bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow} !== 12'h000)
      $display("FAIL reset_w8: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow);
    else n_pass++;
    n_checks++;
    if ({bus1.busy, bus1.done, bus1.diff, bus1.borrow_out, bus1.overflow} !== 5'b00000)
      $display("FAIL reset_w1: got %b, want 00000",
               {bus1.busy, bus1.done, bus1.diff, bus1.borrow_out, bus1.overflow});
    else n_pass++;
    rst_n = 1'b1;
    exp_last_diff = 8'h00;
    @(negedge clk);
  endtask

  // One full operation on the WIDTH=8 instance with latency, busy length and result checks.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic bin, input string name);
    int   edges;
    int   busy_cnt;
    logic unstable;
    res_t e;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.borrow_in = bin;
    q8.push_back(model8(a, b, bin));
    @(negedge clk);
    bus8.start = 1'b0;
    edges = 1; busy_cnt = 0; unstable = 1'b0;
    while (bus8.done !== 1'b1 && edges < 20) begin
      if (bus8.busy === 1'b1) busy_cnt++;
      if (bus8.diff !== exp_last_diff) unstable = 1'b1;
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.borrow_in = 1'($urandom);
      @(negedge clk);
      edges++;
    end
    n_checks++;
    if (edges !== 9) $display("FAIL %s_latency: done after %0d edges, want 9", name, edges);
    else n_pass++;
    n_checks++;
    if (busy_cnt !== 8) $display("FAIL %s_busy_len: busy %0d cycles, want 8", name, busy_cnt);
    else n_pass++;
    n_checks++;
    if (unstable !== 1'b0) $display("FAIL %s_diff_stable: diff changed while busy, want held %h", name, exp_last_diff);
    else n_pass++;
    n_checks++;
    if (q8.size() == 0) begin
      $display("FAIL %s_result: scoreboard empty, want one entry", name);
    end else begin
      e = q8.pop_front();
      if ({bus8.busy, bus8.diff, bus8.borrow_out, bus8.overflow} !== {1'b0, e.diff, e.borrow, e.ovf})
        $display("FAIL %s_result: got busy=%b diff=%h bo=%b ov=%b, want busy=0 diff=%h bo=%b ov=%b",
                 name, bus8.busy, bus8.diff, bus8.borrow_out, bus8.overflow, e.diff, e.borrow, e.ovf);
      else n_pass++;
      exp_last_diff = e.diff;
    end
    @(negedge clk);
    n_checks++;
    if (bus8.done !== 1'b0) $display("FAIL %s_done_pulse: done=%b in following cycle, want 0", name, bus8.done);
    else n_pass++;
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, 1'b0, "sub_5_3");
    run_op(8'h03, 8'h05, 1'b0, "sub_3_5");
    run_op(8'h00, 8'h00, 1'b1, "sub_0_0_bin");
  endtask

  task automatic test_overflow();
    run_op(8'h80, 8'h01, 1'b0, "ovf_80_01");
    run_op(8'h7F, 8'hFF, 1'b0, "ovf_7f_ff");
  endtask

  // start held high with new operands every cycle; a bench-side phase model tracks acceptance.
  task automatic test_back_to_back();
    int   phase = 0;
    int   n_done = 0;
    res_t e;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      n_checks++;
      if ({bus8.busy, bus8.done} !== {(phase >= 1 && phase <= 8), (phase == 9)})
        $display("FAIL b2b_state cyc%0d: got busy=%b done=%b, want busy=%b done=%b", cyc,
                 bus8.busy, bus8.done, (phase >= 1 && phase <= 8), (phase == 9));
      else n_pass++;
      if (phase == 9) begin
        n_done++;
        n_checks++;
        if (q8.size() == 0) begin
          $display("FAIL b2b_result cyc%0d: scoreboard empty", cyc);
        end else begin
          e = q8.pop_front();
          if ({bus8.diff, bus8.borrow_out, bus8.overflow} !== {e.diff, e.borrow, e.ovf})
            $display("FAIL b2b_result cyc%0d: got diff=%h bo=%b ov=%b, want diff=%h bo=%b ov=%b", cyc,
                     bus8.diff, bus8.borrow_out, bus8.overflow, e.diff, e.borrow, e.ovf);
          else n_pass++;
          exp_last_diff = e.diff;
        end
      end else if (phase != 0) begin
        n_checks++;
        if (bus8.diff !== exp_last_diff)
          $display("FAIL b2b_diff_stable cyc%0d: got %h, want %h", cyc, bus8.diff, exp_last_diff);
        else n_pass++;
      end
      bus8.start = (cyc < 45);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.borrow_in = 1'($urandom);
      if (phase == 0) begin
        if (bus8.start) begin
          q8.push_back(model8(bus8.a, bus8.b, bus8.borrow_in));
          phase = 1;
        end
      end else if (phase == 9) begin
        phase = 0;
      end else begin
        phase++;
      end
    end
    bus8.start = 1'b0;
    n_checks++;
    if (q8.size() != 0 || n_done != 5)
      $display("FAIL b2b_drain: %0d left, %0d completed, want 0 left, 5 completed", q8.size(), n_done);
    else n_pass++;
  endtask

  // Asynchronous reset in the middle of RUN must clear outputs at once and suppress done.
  task automatic test_async_reset();
    logic saw_done;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h33; bus8.borrow_in = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus8.busy !== 1'b1) $display("FAIL arst_pre_busy: got %b, want 1", bus8.busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow} !== 12'h000)
      $display("FAIL arst_clear: got busy=%b done=%b diff=%h bo=%b ov=%b, want all 0",
               bus8.busy, bus8.done, bus8.diff, bus8.borrow_out, bus8.overflow);
    else n_pass++;
    exp_last_diff = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL arst_no_done: got done pulse, want none");
    else n_pass++;
    run_op(8'h10, 8'h01, 1'b0, "post_arst");
  endtask

  // Exhaustive WIDTH=1 check: done two edges after acceptance.
  task automatic test_width1();
    logic ta, tb, tbin;
    res_t e;
    for (int i = 0; i < 8; i++) begin
      {ta, tb, tbin} = 3'(i);
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = ta; bus1.b = tb; bus1.borrow_in = tbin;
      e.diff   = {7'd0, ta ^ tb ^ tbin};
      e.borrow = (~ta & tb) | (~(ta ^ tb) & tbin);
      e.ovf    = (ta != tb) && ((ta ^ tb ^ tbin) != ta);
      q1.push_back(e);
      @(negedge clk);
      bus1.start = 1'b0; bus1.a = ~ta; bus1.b = ~tb;
      n_checks++;
      if ({bus1.busy, bus1.done} !== 2'b10)
        $display("FAIL w1_run_%0d: got busy=%b done=%b, want 1 0", i, bus1.busy, bus1.done);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (q1.size() == 0) begin
        $display("FAIL w1_result_%0d: scoreboard empty", i);
      end else begin
        e = q1.pop_front();
        if ({bus1.busy, bus1.done, bus1.diff, bus1.borrow_out, bus1.overflow} !== {2'b01, e.diff[0], e.borrow, e.ovf})
          $display("FAIL w1_result_%0d: got busy=%b done=%b diff=%b bo=%b ov=%b, want 0 1 %b %b %b", i,
                   bus1.busy, bus1.done, bus1.diff, bus1.borrow_out, bus1.overflow, e.diff[0], e.borrow, e.ovf);
        else n_pass++;
      end
      @(negedge clk);
      n_checks++;
      if (bus1.done !== 1'b0) $display("FAIL w1_done_pulse_%0d: got %b, want 0", i, bus1.done);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    test_width1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
